// File: rtl/regfile_bypass.sv
// rtl/regfile_bypass.sv - register file with registered read ports, write bypass and busy scoreboard
module regfile_bypass #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int AW       = $clog2(NREGS),
  parameter int ZERO_REG = 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            read_enable,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  input  logic            write_enable,
  input  logic [AW-1:0]   rd,
  input  logic [XLEN-1:0] result,
  input  logic            reserve_valid,
  input  logic [AW-1:0]   reserve_reg,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  output logic            busy1,
  output logic            busy2
);

  localparam bit ZR = (ZERO_REG != 0);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_next;
  logic             wr_ok;
  logic             rsv_ok;
  logic [XLEN-1:0]  rd1_next;
  logic [XLEN-1:0]  rd2_next;
  logic             busy1_next;
  logic             busy2_next;

  // Writes and reservations to a hardwired zero register are dropped entirely.
  assign wr_ok  = write_enable  && !(ZR && (rd == '0));
  assign rsv_ok = reserve_valid && !(ZR && (reserve_reg == '0));

  // Reserve is applied after the write so a same-edge reservation wins.
  always_comb begin
    busy_next = busy;
    if (wr_ok)  busy_next[rd] = 1'b0;
    if (rsv_ok) busy_next[reserve_reg] = 1'b1;
  end

  always_comb begin
    rd1_next   = (wr_ok && (rd == rs1)) ? result : regs[rs1];
    rd2_next   = (wr_ok && (rd == rs2)) ? result : regs[rs2];
    busy1_next = busy_next[rs1];
    busy2_next = busy_next[rs2];
    if (ZR && (rs1 == '0)) begin
      rd1_next   = '0;
      busy1_next = 1'b0;
    end
    if (ZR && (rs2 == '0)) begin
      rd2_next   = '0;
      busy2_next = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      busy <= '0;
    end else begin
      if (wr_ok) regs[rd] <= result;
      busy <= busy_next;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd1   <= '0;
      rd2   <= '0;
      busy1 <= 1'b0;
      busy2 <= 1'b0;
    end else if (read_enable) begin
      rd1   <= rd1_next;
      rd2   <= rd2_next;
      busy1 <= busy1_next;
      busy2 <= busy2_next;
    end
  end

endmodule
